// File: rtl/rf_writeback_arbiter_if.sv
// rf_writeback_arbiter_if: ALU/load result buses, issue/decode queries and register file write port
interface rf_writeback_arbiter_if #(
  parameter int XLEN = 32,
  parameter int MEM_FIFO_DEPTH = 2
);
  localparam int CW = $clog2(MEM_FIFO_DEPTH) + 1;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_pending;
  logic            rs2_pending;
  logic            rf_enable;
  logic [4:0]      rf_writeadd;
  logic [XLEN-1:0] rf_writedata;
  logic [CW-1:0]   fifo_count;
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, iss_valid, iss_rd, rs1, rs2,
    input  mem_ready, rs1_pending, rs2_pending, rf_enable, rf_writeadd, rf_writedata, fifo_count
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, iss_valid, iss_rd, rs1, rs2,
    output mem_ready, rs1_pending, rs2_pending, rf_enable, rf_writeadd, rf_writedata, fifo_count
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges ALU results (priority) and queued load returns into the registered RF write port, with a RAW pending scoreboard; ports: clock, reset (async active-low), bus (slave modport)
module rf_writeback_arbiter #(
  parameter int MEM_FIFO_DEPTH = 2,
  parameter int XLEN = 32
) (
  input logic clock,
  input logic reset,
  rf_writeback_arbiter_if.slave bus
);
  localparam int AW = $clog2(MEM_FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [4:0]      q_rd_q   [MEM_FIFO_DEPTH];
  logic [4:0]      q_rd_d   [MEM_FIFO_DEPTH];
  logic [XLEN-1:0] q_data_q [MEM_FIFO_DEPTH];
  logic [XLEN-1:0] q_data_d [MEM_FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     pend_q, pend_d;
  logic            rf_enable_q, rf_enable_d;
  logic [4:0]      rf_writeadd_q, rf_writeadd_d;
  logic [XLEN-1:0] rf_writedata_q, rf_writedata_d;
  logic            alu_win, push, pop;
  assign bus.mem_ready    = count_q != CW'(MEM_FIFO_DEPTH);
  assign bus.fifo_count   = count_q;
  assign bus.rf_enable    = rf_enable_q;
  assign bus.rf_writeadd  = rf_writeadd_q;
  assign bus.rf_writedata = rf_writedata_q;
  assign bus.rs1_pending  = pend_q[bus.rs1];
  assign bus.rs2_pending  = pend_q[bus.rs2];
  always_comb begin
    alu_win = bus.alu_valid && bus.alu_rd != 5'd0;
    push = bus.mem_valid && bus.mem_ready && bus.mem_rd != 5'd0;
    pop = !alu_win && count_q != '0;
    q_rd_d = q_rd_q;
    q_data_d = q_data_q;
    if (push) begin
      q_rd_d[wr_ptr_q] = bus.mem_rd;
      q_data_d[wr_ptr_q] = bus.mem_data;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    rf_enable_d = alu_win || pop;
    rf_writeadd_d = alu_win ? bus.alu_rd : pop ? q_rd_q[rd_ptr_q] : rf_writeadd_q;
    rf_writedata_d = alu_win ? bus.alu_data : pop ? q_data_q[rd_ptr_q] : rf_writedata_q;
    // clear from the write retiring this cycle, then set from issue so a same-cycle set wins
    pend_d = (pend_q & ~(rf_enable_q ? 32'd1 << rf_writeadd_q : 32'd0))
           | (bus.iss_valid ? 32'd1 << bus.iss_rd : 32'd0);
    pend_d[0] = 1'b0;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_rd_q <= '{default: '0};
      q_data_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      pend_q <= '0;
      rf_enable_q <= 1'b0;
      rf_writeadd_q <= '0;
      rf_writedata_q <= '0;
    end else begin
      q_rd_q <= q_rd_d;
      q_data_q <= q_data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      pend_q <= pend_d;
      rf_enable_q <= rf_enable_d;
      rf_writeadd_q <= rf_writeadd_d;
      rf_writedata_q <= rf_writedata_d;
    end
  end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed scenarios plus randomized traffic checked against a queue-based reference model
module tb_rf_writeback_arbiter;
  localparam int D = 2;
  localparam int X = 32;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  rf_writeback_arbiter_if #(.XLEN(X), .MEM_FIFO_DEPTH(D)) bus ();
  rf_writeback_arbiter #(.MEM_FIFO_DEPTH(D), .XLEN(X)) dut (.clock(clock), .reset(reset), .bus(bus));
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_t;
  ld_t mq[$];
  logic [31:0] pend;
  logic        m_en;
  logic [4:0]  m_add;
  logic [31:0] m_data;

  task automatic model_reset();
    mq.delete();
    pend = '0;
    m_en = 1'b0;
    m_add = '0;
    m_data = '0;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
  endtask

  task automatic step();
    ld_t e;
    bit rdy;
    #1;
    rdy = mq.size() < D;
    if (m_en) pend[m_add] = 1'b0;
    if (bus.iss_valid && bus.iss_rd != 0) pend[bus.iss_rd] = 1'b1;
    if (bus.alu_valid && bus.alu_rd != 0) begin
      m_en = 1'b1; m_add = bus.alu_rd; m_data = bus.alu_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_en = 1'b1; m_add = e.rd; m_data = e.data;
    end else m_en = 1'b0;
    if (bus.mem_valid && rdy && bus.mem_rd != 0) begin
      e.rd = bus.mem_rd; e.data = bus.mem_data;
      mq.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h55;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd10; bus.mem_data = 32'hA0;
    step();
    bus.iss_valid = 1'b0;
    bus.mem_rd = 5'd11; bus.mem_data = 32'hB0;
    step();
    idle();
    bus.rs1 = 5'd5;
    #1;
    checks++; if (bus.fifo_count !== 2'd2) begin failures++; $display("FAIL rst_pre_count got=%0d exp=2", bus.fifo_count); end
    checks++; if (bus.rs1_pending !== 1'b1) begin failures++; $display("FAIL rst_pre_pend got=%0d exp=1", bus.rs1_pending); end
    reset = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.rf_enable !== 1'b0) begin failures++; $display("FAIL rst_en got=%0d exp=0", bus.rf_enable); end
    checks++; if (bus.rf_writeadd !== 5'd0 || bus.rf_writedata !== 32'd0) begin failures++; $display("FAIL rst_wr got=%0d/%0h exp=0/0", bus.rf_writeadd, bus.rf_writedata); end
    checks++; if (bus.fifo_count !== 2'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.fifo_count); end
    checks++; if (bus.mem_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0d exp=1", bus.mem_ready); end
    checks++; if (bus.rs1_pending !== 1'b0) begin failures++; $display("FAIL rst_pend got=%0d exp=0", bus.rs1_pending); end
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.rf_enable !== 1'b0) begin failures++; $display("FAIL rst_nowrite got=%0d exp=0", bus.rf_enable); end
    end
  endtask

  task automatic test_alu();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hAA;
    step();
    idle();
    checks++; if (bus.rf_enable !== 1'b1 || bus.rf_writeadd !== 5'd3 || bus.rf_writedata !== 32'hAA)
      begin failures++; $display("FAIL alu_write got=%0d/%0d/%0h exp=1/3/aa", bus.rf_enable, bus.rf_writeadd, bus.rf_writedata); end
    step();
    checks++; if (bus.rf_enable !== 1'b0 || bus.rf_writeadd !== 5'd3 || bus.rf_writedata !== 32'hAA)
      begin failures++; $display("FAIL alu_hold got=%0d/%0d/%0h exp=0/3/aa", bus.rf_enable, bus.rf_writeadd, bus.rf_writedata); end
  endtask

  task automatic test_alu_priority();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = $urandom;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      bus.mem_valid = 1'b0;
      if (i == 2) bus.alu_valid = 1'b0;
      checks++; if (bus.rf_writeadd !== 5'd4 || bus.rf_enable !== 1'b1 || bus.fifo_count !== 2'd1)
        begin failures++; $display("FAIL prio_alu%0d got=%0d/%0d/%0d exp=1/4/1", i, bus.rf_enable, bus.rf_writeadd, bus.fifo_count); end
      bus.alu_data = $urandom;
    end
    step();
    checks++; if (bus.rf_enable !== 1'b1 || bus.rf_writeadd !== 5'd7 || bus.rf_writedata !== 32'h1234_5678 || bus.fifo_count !== 2'd0)
      begin failures++; $display("FAIL prio_load got=%0d/%0d/%0h/%0d exp=1/7/12345678/0", bus.rf_enable, bus.rf_writeadd, bus.rf_writedata, bus.fifo_count); end
    step();
    checks++; if (bus.rf_enable !== 1'b0) begin failures++; $display("FAIL prio_idle got=%0d exp=0", bus.rf_enable); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3];
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'($urandom_range(1, 31)); bus.alu_data = $urandom;
      bus.mem_valid = 1'b1; bus.mem_rd = 5'(11 + i); bus.mem_data = d[i];
      step();
    end
    checks++; if (bus.mem_ready !== 1'b0 || bus.fifo_count !== 2'd2)
      begin failures++; $display("FAIL b2b_full got=%0d/%0d exp=0/2", bus.mem_ready, bus.fifo_count); end
    idle();
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.rf_enable !== 1'b1 || bus.rf_writeadd !== 5'(11 + i) || bus.rf_writedata !== d[i])
        begin failures++; $display("FAIL b2b_drain%0d got=%0d/%0d/%0h exp=1/%0d/%0h", i, bus.rf_enable, bus.rf_writeadd, bus.rf_writedata, 11 + i, d[i]); end
    end
    step();
    checks++; if (bus.rf_enable !== 1'b0 || bus.mem_ready !== 1'b1 || bus.fifo_count !== 2'd0)
      begin failures++; $display("FAIL b2b_empty got=%0d/%0d/%0d exp=0/1/0", bus.rf_enable, bus.mem_ready, bus.fifo_count); end
  endtask

  task automatic test_scoreboard();
    bus.rs2 = 5'd9;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    step();
    idle();
    checks++; if (bus.rs2_pending !== 1'b1) begin failures++; $display("FAIL sb_set got=%0d exp=1", bus.rs2_pending); end
    step();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    step();
    idle();
    checks++; if (bus.rs2_pending !== 1'b1 || bus.rf_enable !== 1'b1) begin failures++; $display("FAIL sb_during_write got=%0d/%0d exp=1/1", bus.rs2_pending, bus.rf_enable); end
    step();
    checks++; if (bus.rs2_pending !== 1'b0) begin failures++; $display("FAIL sb_clear got=%0d exp=0", bus.rs2_pending); end
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    step();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9;
    step();
    idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    step();
    idle();
    checks++; if (bus.rs2_pending !== 1'b1) begin failures++; $display("FAIL sb_set_wins got=%0d exp=1", bus.rs2_pending); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9;
    step();
    idle();
    step();
    checks++; if (bus.rs2_pending !== 1'b0) begin failures++; $display("FAIL sb_reclear got=%0d exp=0", bus.rs2_pending); end
  endtask

  task automatic test_zero_rd();
    bus.rs1 = 5'd0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hDEAD;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'hBEEF;
    step();
    checks++; if (bus.rf_enable !== 1'b0 || bus.fifo_count !== 2'd0 || bus.rs1_pending !== 1'b0)
      begin failures++; $display("FAIL zero_rd got=%0d/%0d/%0d exp=0/0/0", bus.rf_enable, bus.fifo_count, bus.rs1_pending); end
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd6; bus.mem_data = 32'h66;
    step();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1;
    step();
    idle();
    checks++; if (bus.rf_enable !== 1'b1 || bus.rf_writeadd !== 5'd6 || bus.rf_writedata !== 32'h66)
      begin failures++; $display("FAIL zero_alu_pop got=%0d/%0d/%0h exp=1/6/66", bus.rf_enable, bus.rf_writeadd, bus.rf_writedata); end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.alu_valid = $urandom_range(0, 2) == 0;
      bus.alu_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.alu_data = $urandom;
      bus.mem_valid = $urandom_range(0, 1) == 1;
      bus.mem_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.mem_data = $urandom;
      bus.iss_valid = $urandom_range(0, 2) == 0;
      bus.iss_rd = 5'($urandom);
      bus.rs1 = 5'($urandom);
      bus.rs2 = 5'($urandom);
      #1;
      checks++; if (bus.mem_ready !== (mq.size() < D)) begin failures++; $display("FAIL rnd_ready[%0d] got=%0d exp=%0d", i, bus.mem_ready, mq.size() < D); end
      checks++; if (bus.rs1_pending !== pend[bus.rs1] || bus.rs2_pending !== pend[bus.rs2])
        begin failures++; $display("FAIL rnd_pend[%0d] got=%0d/%0d exp=%0d/%0d", i, bus.rs1_pending, bus.rs2_pending, pend[bus.rs1], pend[bus.rs2]); end
      step();
      checks++; if (bus.rf_enable !== m_en) begin failures++; $display("FAIL rnd_en[%0d] got=%0d exp=%0d", i, bus.rf_enable, m_en); end
      checks++; if (bus.rf_writeadd !== m_add || bus.rf_writedata !== m_data)
        begin failures++; $display("FAIL rnd_wr[%0d] got=%0d/%0h exp=%0d/%0h", i, bus.rf_writeadd, bus.rf_writedata, m_add, m_data); end
      checks++; if (bus.fifo_count !== 2'(mq.size())) begin failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, bus.fifo_count, mq.size()); end
    end
    idle();
  endtask

  initial begin
    idle();
    bus.rs1 = '0;
    bus.rs2 = '0;
    model_reset();
    @(posedge clock);
    #1;
    test_reset();
    test_alu();
    test_alu_priority();
    test_back_to_back();
    test_scoreboard();
    test_zero_rd();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
